regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL provide parameter FAIR_DEFAULT, default 1, meaning the reset value of the round-robin pointer (1 = requester B served first on the first tie).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port halt_sys, input, 1, system halt; when high, no new grants.
REQ-005 The block SHALL have ports a_valid (in, 1), a_ready (out, 1), a_addr (in, 4), a_data (in, 32), a_r0_en (in, 1): requester A, the ALU/mul/div writeback; a_r0_en requests the high word into R0.
REQ-006 The block SHALL have ports b_valid (in, 1), b_ready (out, 1), b_addr (in, 4), b_data (in, 16): requester B, the load writeback, low word only.
REQ-007 The block SHALL have ports wb_we (out, 1), wb_r0_en (out, 1), wb_addr (out, 4), wb_data (out, 32): the register-file write port; wb_we high = write this cycle.
REQ-008 The block SHALL have port conflict (out, 1), a one-cycle pulse flagging an A write with a_r0_en=1 and a_addr=0.
REQ-009 The block SHALL have port grant_cnt (out, 8), the count of completed writes.

Function
REQ-010 A transfer SHALL occur on a requester when valid and ready are both high at a rising edge; ready SHALL be combinational from valid, halt_sys and the arbitration state only.
REQ-011 a_ready and b_ready SHALL never be high in the same cycle; both SHALL be low while halt_sys=1 or the FSM is in HALT.
REQ-012 The FSM SHALL have states IDLE, WRITE and HALT; reset enters IDLE.
REQ-013 IDLE->WRITE on any transfer; IDLE->HALT when halt_sys=1 with no transfer; WRITE->WRITE on a new transfer; WRITE->IDLE with no transfer and halt_sys=0; WRITE->HALT when halt_sys=1; HALT->IDLE when halt_sys=0.
REQ-014 wb_* outputs SHALL be registered; a transfer at edge N SHALL present wb_we=1 with the captured fields for exactly the cycle after edge N (latency 1), and back-to-back transfers SHALL produce one write per cycle.
REQ-015 For a B transfer wb_data SHALL be {16'h0000, b_data} and wb_r0_en SHALL be 0.
REQ-016 For an A transfer wb_data SHALL be a_data and wb_r0_en SHALL equal a_r0_en, except REQ-017.
REQ-017 If an A transfer has a_r0_en=1 and a_addr=0, wb_r0_en SHALL be 0 (the low word wins), and conflict SHALL pulse in the same cycle as that write.
REQ-018 A write already registered when halt_sys rises SHALL still be presented; halt only blocks new transfers.
REQ-019 With one requester valid, it SHALL be granted; with both valid, the arbitration SHALL follow the Configuration section.
REQ-020 When wb_we is low, wb_r0_en SHALL be 0, and wb_addr/wb_data SHALL hold their previous values.
REQ-021 grant_cnt SHALL increment by 1 on each cycle with wb_we=1 and wrap from 255 to 0.

Reset
REQ-022 While rst=0 at a rising edge, the block SHALL set wb_we=0, wb_r0_en=0, wb_addr=0, wb_data=0, conflict=0, grant_cnt=0, FSM=IDLE and the round-robin pointer=FAIR_DEFAULT.
REQ-023 While rst=0, a_ready and b_ready SHALL be 0, and a write pending at the reset edge SHALL be discarded (wb_we=0 on the following cycle).

Configuration
REQ-024 With WB_FAIRNESS_EN defined, ties SHALL be resolved round-robin: the pointer selects the requester to win, and the pointer SHALL then point to the other requester after each tie grant.
REQ-025 Without WB_FAIRNESS_EN, A SHALL always win ties, with no pointer state (FAIR_DEFAULT is ignored).

Verification
REQ-026 Reset then b_valid=1, b_addr=3, b_data=16'hBEEF for one cycle -> the next cycle has wb_we=1, wb_addr=3, wb_data=32'h0000BEEF, wb_r0_en=0, and grant_cnt=1 after that cycle.
REQ-027 a_valid=1, a_addr=5, a_data=32'h12345678, a_r0_en=1 -> one cycle later wb_we=1, wb_r0_en=1, wb_addr=5, wb_data=32'h12345678.
REQ-028 A and B both valid for 4 cycles with WB_FAIRNESS_EN and FAIR_DEFAULT=1 -> grant order B,A,B,A; without the macro -> A,A,A,A with b_ready=0 throughout.
REQ-029 halt_sys raised on the same edge as a transfer -> that write still issues; then a_ready=b_ready=0 and wb_we=0 until halt_sys falls, then service resumes the cycle after the FSM returns to IDLE.
REQ-030 A transfer with a_addr=0, a_r0_en=1 -> wb_r0_en=0, wb_addr=0, one-cycle conflict pulse; rst=0 asserted mid-stream -> wb_we=0 and grant_cnt=0 on the next cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : regfile_wb_arbiter_if                                       |
// | Brief    : Bundles the two writeback requesters, the system halt, the  |
// |            register-file write port and the status outputs.            |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface regfile_wb_arbiter_if;
    logic        halt_sys;

    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_addr;
    logic [31:0] a_data;
    logic        a_r0_en;

    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_addr;
    logic [15:0] b_data;

    logic        wb_we;
    logic        wb_r0_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        conflict;
    logic [7:0]  grant_cnt;

    // Requester / pipeline side
    modport master (
        output halt_sys,
        output a_valid, a_addr, a_data, a_r0_en,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  wb_we, wb_r0_en, wb_addr, wb_data, conflict, grant_cnt
    );

    // Arbiter side
    modport slave (
        input  halt_sys,
        input  a_valid, a_addr, a_data, a_r0_en,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output wb_we, wb_r0_en, wb_addr, wb_data, conflict, grant_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : regfile_wb_arbiter                                          |
// | Brief    : Arbitrates the ALU (A) and load (B) writeback requesters    |
// |            onto a single registered register-file write port.         |
// |            Optional macro WB_FAIRNESS_EN: round-robin tie resolution; |
// |            without it requester A always wins a tie.                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module regfile_wb_arbiter #(
    parameter int FAIR_DEFAULT = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_HALT  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        w_open;
    logic        w_tie;
    logic        w_b_wins_tie;
    logic        w_a_grant;
    logic        w_b_grant;
    logic        w_xfer;
    logic        w_conflict;

    logic        r_wb_we;
    logic        r_wb_r0_en;
    logic [3:0]  r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_conflict;
    logic [7:0]  r_grant_cnt;

    // New grants are only possible out of reset, with no halt request and
    // once the FSM has left HALT.
    assign w_open = rst && !bus.halt_sys && (r_state != c_ST_HALT);
    assign w_tie  = bus.a_valid && bus.b_valid;

`ifdef WB_FAIRNESS_EN
    logic r_rr_ptr;

    assign w_b_wins_tie = r_rr_ptr;

    // Round-robin pointer: flips to the other requester after each tie grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr <= (FAIR_DEFAULT != 0);
        end else if (w_xfer && w_tie) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end
`else
    logic w_unused_fair;

    // Fixed priority: A wins every tie, so the pointer reset value is moot.
    assign w_b_wins_tie  = 1'b0;
    assign w_unused_fair = (FAIR_DEFAULT != 0);
`endif

    // Ready is a pure function of valid, halt and the arbitration state;
    // at most one requester is granted per cycle.
    assign w_a_grant   = w_open && bus.a_valid && (!w_tie || !w_b_wins_tie);
    assign w_b_grant   = w_open && bus.b_valid && (!w_tie ||  w_b_wins_tie);
    assign w_xfer      = w_a_grant || w_b_grant;
    assign bus.a_ready = w_a_grant;
    assign bus.b_ready = w_b_grant;

    // A high-word request aimed at R0 clashes with the low-word write.
    assign w_conflict  = w_a_grant && bus.a_r0_en && (bus.a_addr == 4'd0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = c_ST_WRITE;
                end else if (bus.halt_sys) begin
                    w_state_nxt = c_ST_HALT;
                end
            end
            c_ST_WRITE: begin
                if (w_xfer) begin
                    w_state_nxt = c_ST_WRITE;
                end else if (bus.halt_sys) begin
                    w_state_nxt = c_ST_HALT;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_HALT: begin
                if (!bus.halt_sys) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Writeback register: capture the granted request, hold fields when idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb_we     <= 1'b0;
            r_wb_r0_en  <= 1'b0;
            r_wb_addr   <= 4'd0;
            r_wb_data   <= 32'd0;
            r_conflict  <= 1'b0;
        end else begin
            r_wb_we    <= w_xfer;
            r_conflict <= w_conflict;
            if (w_a_grant) begin
                r_wb_addr  <= bus.a_addr;
                r_wb_data  <= bus.a_data;
                r_wb_r0_en <= bus.a_r0_en && !w_conflict;
            end else if (w_b_grant) begin
                r_wb_addr  <= bus.b_addr;
                r_wb_data  <= {16'h0000, bus.b_data};
                r_wb_r0_en <= 1'b0;
            end else begin
                r_wb_r0_en <= 1'b0;
            end
        end
    end

    // Completed-write counter, advanced at the end of each write cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant_cnt <= 8'd0;
        end else begin
            r_grant_cnt <= r_grant_cnt + {7'd0, r_wb_we};
        end
    end

    assign bus.wb_we     = r_wb_we;
    assign bus.wb_r0_en  = r_wb_r0_en;
    assign bus.wb_addr   = r_wb_addr;
    assign bus.wb_data   = r_wb_data;
    assign bus.conflict  = r_conflict;
    assign bus.grant_cnt = r_grant_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_regfile_wb_arbiter                                       |
// | Brief    : Directed self-checking bench with a transaction-level model |
// |            of the writeback arbiter compared every cycle.              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

    localparam int FAIR = 1;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.FAIR_DEFAULT(FAIR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what the write port must show in the current cycle
    bit          m_live;
    logic        m_we;
    logic        m_r0;
    logic        m_conf;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    logic [7:0]  m_cnt;
    logic        m_halted;   // halt_sys was seen high at the last edge
    logic        m_ptr;      // 1: B takes the next tie

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Expected {a_ready, b_ready} from the arbitration rules
    function automatic logic [1:0] exp_ready();
        logic bw;
`ifdef WB_FAIRNESS_EN
        bw = m_ptr;
`else
        bw = 1'b0;
`endif
        if (!rst || bus.halt_sys || m_halted) return 2'b00;
        if (bus.a_valid && bus.b_valid) return bw ? 2'b01 : 2'b10;
        return {bus.a_valid, bus.b_valid};
    endfunction

    // Transaction model, advanced on every rising edge
    always @(posedge clk) begin
        logic [1:0] g;
        g = exp_ready();
        if (!rst) begin
            m_live   = 1'b1;
            m_we     = 1'b0;
            m_r0     = 1'b0;
            m_conf   = 1'b0;
            m_addr   = 4'd0;
            m_data   = 32'd0;
            m_cnt    = 8'd0;
            m_halted = 1'b0;
            m_ptr    = (FAIR != 0);
        end else begin
            m_cnt  = m_cnt + (m_we ? 8'd1 : 8'd0);
            m_we   = 1'b0;
            m_r0   = 1'b0;
            m_conf = 1'b0;
            if (g[1]) begin
                m_we   = 1'b1;
                m_addr = bus.a_addr;
                m_data = bus.a_data;
                if (bus.a_r0_en && bus.a_addr == 4'd0) m_conf = 1'b1;
                else m_r0 = bus.a_r0_en;
            end else if (g[0]) begin
                m_we   = 1'b1;
                m_addr = bus.b_addr;
                m_data = {16'h0000, bus.b_data};
            end
            if (g != 2'b00 && bus.a_valid && bus.b_valid) m_ptr = !m_ptr;
            m_halted = bus.halt_sys;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            logic [1:0] r;
            r = exp_ready();
            chk("a_ready",   bus.a_ready,   r[1]);
            chk("b_ready",   bus.b_ready,   r[0]);
            chk("wb_we",     bus.wb_we,     m_we);
            chk("wb_r0_en",  bus.wb_r0_en,  m_r0);
            chk("wb_addr",   bus.wb_addr,   m_addr);
            chk("wb_data",   bus.wb_data,   m_data);
            chk("conflict",  bus.conflict,  m_conf);
            chk("grant_cnt", bus.grant_cnt, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        m_live = 1'b0;
        rst = 1'b0;
        bus.halt_sys = 1'b0;
        bus.a_valid = 1'b0; bus.a_addr = 4'd0; bus.a_data = 32'd0; bus.a_r0_en = 1'b0;
        bus.b_valid = 1'b0; bus.b_addr = 4'd0; bus.b_data = 16'd0;

        // Reset: outputs cleared, ready held low even with a request
        step(); step();
        bus.a_valid = 1'b1;
        at_neg();
        chk("lit_rst_a_ready", bus.a_ready, 1'b0);
        chk("lit_rst_wb_we", bus.wb_we, 1'b0);
        chk("lit_rst_cnt", bus.grant_cnt, 8'd0);
        step();
        rst = 1'b1;
        bus.a_valid = 1'b0;
        step();

        // Single load writeback
        bus.b_valid = 1'b1; bus.b_addr = 4'd3; bus.b_data = 16'hBEEF;
        at_neg();
        chk("lit_b_ready", bus.b_ready, 1'b1);
        step();
        bus.b_valid = 1'b0;
        at_neg();
        chk("lit_b_we", bus.wb_we, 1'b1);
        chk("lit_b_addr", bus.wb_addr, 4'd3);
        chk("lit_b_data", bus.wb_data, 32'h0000BEEF);
        chk("lit_b_r0", bus.wb_r0_en, 1'b0);
        step();
        at_neg();
        chk("lit_b_cnt", bus.grant_cnt, 8'd1);
        chk("lit_b_hold_data", bus.wb_data, 32'h0000BEEF);
        step();

        // Single ALU writeback with high-word request
        bus.a_valid = 1'b1; bus.a_addr = 4'd5; bus.a_data = 32'h12345678; bus.a_r0_en = 1'b1;
        step();
        bus.a_valid = 1'b0; bus.a_r0_en = 1'b0;
        at_neg();
        chk("lit_a_r0", bus.wb_r0_en, 1'b1);
        chk("lit_a_data", bus.wb_data, 32'h12345678);
        step();

        // Four cycles of ties
        for (int i = 0; i < 4; i++) begin
            logic eb;
            bus.a_valid = 1'b1; bus.a_addr = 4'(8 + i); bus.a_data = 32'hA000_0000 + 32'(i);
            bus.b_valid = 1'b1; bus.b_addr = 4'(i);     bus.b_data = 16'hB000 + 16'(i);
`ifdef WB_FAIRNESS_EN
            eb = (i % 2 == 0);
`else
            eb = 1'b0;
`endif
            at_neg();
            chk("lit_tie_b_ready", bus.b_ready, eb);
            chk("lit_tie_a_ready", bus.a_ready, !eb);
            step();
        end

        // Halt rising right after a transfer edge
        bus.b_valid = 1'b0; bus.a_addr = 4'd9; bus.a_data = 32'hCAFE_0001;
        step();
        bus.halt_sys = 1'b1; bus.b_valid = 1'b1;
        at_neg();
        chk("lit_halt_write_kept", bus.wb_we, 1'b1);
        chk("lit_halt_rdy", {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            at_neg();
            chk("lit_halt_we", bus.wb_we, 1'b0);
        end
        step();
        bus.halt_sys = 1'b0; bus.b_valid = 1'b0;
        at_neg();
        chk("lit_halt_exit_rdy", bus.a_ready, 1'b0);
        step();
        at_neg();
        chk("lit_resume_rdy", bus.a_ready, 1'b1);
        step();
        bus.a_valid = 1'b0;
        at_neg();
        chk("lit_resume_we", bus.wb_we, 1'b1);
        step();

        // R0 high/low word conflict
        bus.a_valid = 1'b1; bus.a_addr = 4'd0; bus.a_data = 32'h5555_AAAA; bus.a_r0_en = 1'b1;
        step();
        bus.a_valid = 1'b0; bus.a_r0_en = 1'b0;
        at_neg();
        chk("lit_conf_pulse", bus.conflict, 1'b1);
        chk("lit_conf_r0", bus.wb_r0_en, 1'b0);
        chk("lit_conf_addr", bus.wb_addr, 4'd0);
        step();
        at_neg();
        chk("lit_conf_end", bus.conflict, 1'b0);

        // Reset asserted in the middle of a stream
        bus.a_valid = 1'b1; bus.a_addr = 4'd7; bus.a_data = 32'h0000_0777;
        step(); step(); step();
        rst = 1'b0;
        at_neg();
        chk("lit_mid_rst_rdy", bus.a_ready, 1'b0);
        step();
        at_neg();
        chk("lit_mid_rst_we", bus.wb_we, 1'b0);
        chk("lit_mid_rst_cnt", bus.grant_cnt, 8'd0);
        step();
        rst = 1'b1; bus.a_valid = 1'b0;
        step();

        // Counter wrap: 257 back-to-back load writes
        bus.b_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            bus.b_addr = 4'(i);
            bus.b_data = 16'(i * 3);
            step();
        end
        bus.b_valid = 1'b0;
        at_neg();
        chk("lit_wrap_cnt0", bus.grant_cnt, 8'd0);
        step();
        at_neg();
        chk("lit_wrap_cnt1", bus.grant_cnt, 8'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
